// File: rtl/irq_nmi_gen.sv
// -----------------------------------------------------------------------------
// irq_nmi_gen
//   Generates the maskable IRQ from the rising edge of VBLANK and a periodic NMI
//   from a programmable timer. Both requests are levels that the CPU clears by
//   fetching the matching vector (0x0038 for IRQ, 0x0066 for NMI).
//
// Parameters
//   IRQEN_ADDR   CPU write address of the IRQ enable latch (DO[0])
//   NMICTL_ADDR  CPU write address of the NMI timer control register
//   NMI_STOP     control value that stops the NMI timer
//   NMI_PERIOD   NMI period in unpaused clock cycles (2..65535)
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   PAUSE    in   freezes the NMI counter and the VBLANK edge detector
//   VBLANK   in   asynchronous vertical blank level
//   WR       in   CPU write strobe (one cycle per write)
//   AD       in   CPU address bus
//   DO       in   CPU write data
//   ACK_EN   in   AD carries an opcode/vector fetch
//   IRQ      out  maskable interrupt request (level)
//   NMI      out  non-maskable interrupt request (level)
//   NMI_RUN  out  NMI timer running
//   NMI_OVR  out  sticky: a period expired while NMI was still pending
// -----------------------------------------------------------------------------
module irq_nmi_gen #(
    parameter logic [15:0] IRQEN_ADDR  = 16'h6820,
    parameter logic [15:0] NMICTL_ADDR = 16'h7100,
    parameter logic [7:0]  NMI_STOP    = 8'h10,
    parameter logic [15:0] NMI_PERIOD  = 16'd3072
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PAUSE,
    input  logic        VBLANK,
    input  logic        WR,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        ACK_EN,
    output logic        IRQ,
    output logic        NMI,
    output logic        NMI_RUN,
    output logic        NMI_OVR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PEND  = 2'b10
    } nmi_state_t;

    localparam logic [15:0] RELOAD_VAL = NMI_PERIOD - 16'd1;
    localparam logic [15:0] IRQ_VEC    = 16'h0038;
    localparam logic [15:0] NMI_VEC    = 16'h0066;

    logic        vb_sync1_r;
    logic        vb_sync2_r;
    logic        vb_last_r;
    logic        irq_en_r;
    logic        irq_r;
    logic        nmi_r;
    logic        nmi_run_r;
    logic        nmi_ovr_r;
    logic [15:0] cnt_r;
    nmi_state_t  state_r;

    logic        irqen_wr_s;
    logic        irq_dis_s;
    logic        nmictl_wr_s;
    logic        irq_ack_s;
    logic        nmi_ack_s;
    logic        vb_edge_s;
    logic        expire_s;

    assign irqen_wr_s  = WR & (AD == IRQEN_ADDR);
    assign irq_dis_s   = irqen_wr_s & ~DO[0];
    assign nmictl_wr_s = WR & (AD == NMICTL_ADDR);
    assign irq_ack_s   = ACK_EN & (AD == IRQ_VEC);
    assign nmi_ack_s   = ACK_EN & (AD == NMI_VEC);
    // The edge detector is frozen while paused, so an edge that arrives during
    // PAUSE is reported once PAUSE drops.
    assign vb_edge_s   = ~PAUSE & vb_sync2_r & ~vb_last_r;
    assign expire_s    = ~PAUSE & (cnt_r == 16'd0);

    assign IRQ     = irq_r;
    assign NMI     = nmi_r;
    assign NMI_RUN = nmi_run_r;
    assign NMI_OVR = nmi_ovr_r;

    // VBLANK two-flop synchronizer and edge-detector history.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vb_sync1_r <= 1'b0;
            vb_sync2_r <= 1'b0;
            vb_last_r  <= 1'b0;
        end else begin
            vb_sync1_r <= VBLANK;
            vb_sync2_r <= vb_sync1_r;
            if (!PAUSE) begin
                vb_last_r <= vb_sync2_r;
            end else begin
                vb_last_r <= vb_last_r;
            end
        end
    end

    // IRQ enable latch and IRQ request; disable beats set, set beats acknowledge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (irqen_wr_s) begin
                irq_en_r <= DO[0];
            end else begin
                irq_en_r <= irq_en_r;
            end

            if (irq_dis_s) begin
                irq_r <= 1'b0;
            end else if (vb_edge_s && irq_en_r) begin
                irq_r <= 1'b1;
            end else if (irq_ack_s) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    // NMI timer state machine; control write beats expiry beats acknowledge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            nmi_r     <= 1'b0;
            nmi_run_r <= 1'b0;
            nmi_ovr_r <= 1'b0;
        end else if (nmictl_wr_s) begin
            nmi_r <= 1'b0;
            if (DO == NMI_STOP) begin
                state_r   <= ST_IDLE;
                cnt_r     <= 16'd0;
                nmi_run_r <= 1'b0;
                nmi_ovr_r <= 1'b0;
            end else begin
                state_r   <= ST_COUNT;
                cnt_r     <= RELOAD_VAL;
                nmi_run_r <= 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    nmi_run_r <= 1'b0;
                end
                ST_COUNT: begin
                    if (expire_s) begin
                        nmi_r   <= 1'b1;
                        cnt_r   <= RELOAD_VAL;
                        state_r <= ST_PEND;
                    end else if (!PAUSE) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_PEND: begin
                    if (expire_s) begin
                        // An acknowledge landing on the expiry cycle just
                        // re-arms NMI without counting as an overrun.
                        cnt_r <= RELOAD_VAL;
                        if (!nmi_ack_s) begin
                            nmi_ovr_r <= 1'b1;
                        end else begin
                            nmi_ovr_r <= nmi_ovr_r;
                        end
                    end else begin
                        if (!PAUSE) begin
                            cnt_r <= cnt_r - 16'd1;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        if (nmi_ack_s) begin
                            nmi_r   <= 1'b0;
                            state_r <= ST_COUNT;
                        end else begin
                            nmi_r <= nmi_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 16'd0;
                    nmi_r     <= 1'b0;
                    nmi_run_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_nmi_gen.sv
// -----------------------------------------------------------------------------
// tb_irq_nmi_gen
//   Self-checking bench for irq_nmi_gen with NMI_PERIOD = 4. Directed scenarios
//   for the interrupt behaviours, then randomized traffic, all checked against a
//   behavioural model that tracks "clocks left until the NMI period expires".
// -----------------------------------------------------------------------------
module tb_irq_nmi_gen;

    localparam logic [15:0] IRQEN  = 16'h6820;
    localparam logic [15:0] NMICTL = 16'h7100;
    localparam int          P      = 4;

    logic        CLK;
    logic        RESET_N;
    logic        PAUSE;
    logic        VBLANK;
    logic        WR;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        ACK_EN;
    logic        IRQ;
    logic        NMI;
    logic        NMI_RUN;
    logic        NMI_OVR;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_irq, m_irq_en, m_nmi, m_ovr, m_run;
    int m_left;              // unpaused clocks until next expiry
    bit m_vb1, m_vb2;        // VBLANK as seen one / two edges ago
    bit m_vb_last;           // last synchronized value seen while unpaused

    irq_nmi_gen #(
        .IRQEN_ADDR (16'h6820),
        .NMICTL_ADDR(16'h7100),
        .NMI_STOP   (8'h10),
        .NMI_PERIOD (16'd4)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .PAUSE  (PAUSE),
        .VBLANK (VBLANK),
        .WR     (WR),
        .AD     (AD),
        .DO     (DO),
        .ACK_EN (ACK_EN),
        .IRQ    (IRQ),
        .NMI    (NMI),
        .NMI_RUN(NMI_RUN),
        .NMI_OVR(NMI_OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_irq = 0; m_irq_en = 0; m_nmi = 0; m_ovr = 0; m_run = 0;
        m_left = 0; m_vb1 = 0; m_vb2 = 0; m_vb_last = 0;
    endtask

    // Advance the model by one clock using the current inputs, clock the DUT,
    // then compare every output. Called and returns at a falling edge.
    task automatic step();
        bit edge_seen, ack_irq, ack_nmi, expire;
        edge_seen = !PAUSE && m_vb2 && !m_vb_last;
        ack_irq   = ACK_EN && (AD == 16'h0038);
        ack_nmi   = ACK_EN && (AD == 16'h0066);

        if (WR && AD == IRQEN && !DO[0])   m_irq = 0;
        else if (edge_seen && m_irq_en)    m_irq = 1;
        else if (ack_irq)                  m_irq = 0;
        if (WR && AD == IRQEN) m_irq_en = DO[0];

        if (!PAUSE) m_vb_last = m_vb2;
        m_vb2 = m_vb1;
        m_vb1 = VBLANK;

        expire = m_run && !PAUSE && (m_left == 1);
        if (WR && AD == NMICTL) begin
            m_nmi = 0;
            if (DO == 8'h10) begin
                m_run = 0; m_ovr = 0; m_left = 0;
            end else begin
                m_run = 1; m_left = P;
            end
        end else if (expire) begin
            m_left = P;
            if (m_nmi && !ack_nmi) m_ovr = 1;
            m_nmi = 1;
        end else begin
            if (m_run && !PAUSE) m_left--;
            if (m_nmi && ack_nmi) m_nmi = 0;
        end

        @(posedge CLK);
        #1;
        check("irq", IRQ, m_irq);
        check("nmi", NMI, m_nmi);
        check("nmi_run", NMI_RUN, m_run);
        check("nmi_ovr", NMI_OVR, m_ovr);
        @(negedge CLK);
    endtask

    task automatic drive(input logic wr, input logic [15:0] ad, input logic [7:0] dat,
                         input logic ack);
        WR = wr; AD = ad; DO = dat; ACK_EN = ack;
        step();
        WR = 1'b0; ACK_EN = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    // Pulse reset for one clock; outputs must drop before any clock edge.
    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        check("rst_irq", IRQ, 1'b0);
        check("rst_nmi", NMI, 1'b0);
        check("rst_run", NMI_RUN, 1'b0);
        check("rst_ovr", NMI_OVR, 1'b0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b1; PAUSE = 1'b0; VBLANK = 1'b0;
        WR = 1'b0; AD = 16'h0000; DO = 8'h00; ACK_EN = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset();
        idle();

        // IRQ: enable, VBLANK rise -> IRQ on the third clock, acknowledge clears
        drive(1'b1, IRQEN, 8'h01, 1'b0);
        VBLANK = 1'b1;
        idle(); idle();
        check("irq_not_yet", IRQ, 1'b0);
        idle();
        check("irq_set_3clk", IRQ, 1'b1);
        drive(1'b0, 16'h0038, 8'h00, 1'b1);
        check("irq_ack", IRQ, 1'b0);
        VBLANK = 1'b0;
        idle(); idle(); idle();

        // IRQ masked for three VBLANK pulses, then disable write clears IRQ
        drive(1'b1, IRQEN, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            VBLANK = 1'b1;
            idle(); idle(); idle();
            VBLANK = 1'b0;
            idle(); idle(); idle();
            check("irq_masked", IRQ, 1'b0);
        end
        drive(1'b1, IRQEN, 8'h01, 1'b0);
        VBLANK = 1'b1;
        idle(); idle(); idle();
        check("irq_set_again", IRQ, 1'b1);
        drive(1'b1, IRQEN, 8'h00, 1'b0);
        check("irq_disable_clr", IRQ, 1'b0);
        VBLANK = 1'b0;
        idle(); idle(); idle();

        // NMI period 4, acknowledged each time
        drive(1'b1, NMICTL, 8'h71, 1'b0);
        check("nmi_run_start", NMI_RUN, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("nmi_wait", NMI, 1'b0);
            idle();
        end
        check("nmi_wait3", NMI, 1'b0);
        idle();
        check("nmi_at_4", NMI, 1'b1);
        drive(1'b0, 16'h0066, 8'h00, 1'b1);
        check("nmi_ack", NMI, 1'b0);
        idle(); idle();
        check("nmi_wait_7", NMI, 1'b0);
        idle();
        check("nmi_at_8", NMI, 1'b1);
        drive(1'b1, NMICTL, 8'h10, 1'b0);

        // NMI never acknowledged -> overrun at the 8th clock, then stop
        drive(1'b1, NMICTL, 8'h55, 1'b0);
        idle(); idle(); idle(); idle();
        check("ovr_nmi4", NMI, 1'b1);
        check("ovr_not_yet", NMI_OVR, 1'b0);
        idle(); idle(); idle();
        check("ovr_pre8", NMI_OVR, 1'b0);
        idle();
        check("ovr_at_8", NMI_OVR, 1'b1);
        check("ovr_nmi_held", NMI, 1'b1);
        drive(1'b1, NMICTL, 8'h10, 1'b0);
        check("stop_nmi", NMI, 1'b0);
        check("stop_ovr", NMI_OVR, 1'b0);
        check("stop_run", NMI_RUN, 1'b0);

        // PAUSE for 10 clocks delays NMI by exactly 10 clocks
        drive(1'b1, NMICTL, 8'h01, 1'b0);
        idle(); idle();
        PAUSE = 1'b1;
        for (int k = 0; k < 10; k++) idle();
        PAUSE = 1'b0;
        idle();
        check("pause_nmi_13", NMI, 1'b0);
        idle();
        check("pause_nmi_14", NMI, 1'b1);
        idle(); idle(); idle();
        drive(1'b0, 16'h0066, 8'h00, 1'b1);
        check("ack_expire_nmi", NMI, 1'b1);
        check("ack_expire_ovr", NMI_OVR, 1'b0);

        // Reset while NMI pending with VBLANK high: nothing afterwards
        idle();
        VBLANK = 1'b1;
        do_reset();
        for (int k = 0; k < 2 * P; k++) begin
            idle();
            check("post_rst_nmi", NMI, 1'b0);
            check("post_rst_irq", IRQ, 1'b0);
        end
        VBLANK = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            case ($urandom_range(0, 4))
                0:       a = IRQEN;
                1:       a = NMICTL;
                2:       a = 16'h0038;
                3:       a = 16'h0066;
                default: a = 16'($urandom);
            endcase
            d = ($urandom_range(0, 2) == 0) ? 8'h10 : 8'($urandom);
            if ($urandom_range(0, 4) == 0) VBLANK = ~VBLANK;
            PAUSE = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 7) == 0, a, d, $urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
